// File: rtl/arb_requester_4ch.sv
// rtl/arb_requester_4ch.sv - requester-side companion to a 4-channel fixed-priority arbiter
// Optional REQ-state abandon timer is compiled in with ARB_REQ_TIMEOUT_EN.
module arb_requester_4ch #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] push,
  output logic [NCH-1:0] req_out,
  input  logic [NCH-1:0] grant_in,
  output logic [NCH-1:0] owner,
  output logic [NCH-1:0] done,
  output logic           lost_grant,
  output logic           grant_err,
  output logic [NCH-1:0] overflow,
  output logic           timeout
);

  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

  state_t           state;
  logic [CNT_W-1:0] pend [NCH];
  logic [7:0]       hold;
  logic [NCH-1:0]   pend_nz;
  logic [NCH-1:0]   complete;
  logic             grant_ok;
  logic             grant_bad;
  logic             wait_expired;

  always_comb begin
    pend_nz = '0;
    for (int i = 0; i < NCH; i++) pend_nz[i] = (pend[i] != '0);
  end

  // A legal grant is exactly one bit and lands on a channel we are requesting.
  assign grant_ok  = $onehot(grant_in) && ((grant_in & req_out) != '0);
  assign grant_bad = (grant_in != '0) && !grant_ok;

  assign complete = (state == OWN && hold == 8'd0 && (grant_in & owner) != '0) ? owner : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) pend[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i] && !complete[i]) begin
          if (pend[i] == '1) overflow[i] <= 1'b1;
          else               pend[i]     <= pend[i] + CNT_W'(1);
        end else if (!push[i] && complete[i]) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (state == REQ && !grant_ok && wait_cnt != 8'(TIMEOUT - 1))
      wait_cnt <= wait_cnt + 8'd1;
    else
      wait_cnt <= '0;
  end

  assign wait_expired = (state == REQ) && !grant_ok && (wait_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign wait_expired   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_out    <= '0;
      owner      <= '0;
      done       <= '0;
      lost_grant <= 1'b0;
      grant_err  <= 1'b0;
      timeout    <= 1'b0;
      hold       <= '0;
    end else begin
      done       <= '0;
      lost_grant <= 1'b0;
      grant_err  <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // pend_nz is zero unless we are leaving, so this keeps req_out low in IDLE.
          req_out <= pend_nz;
          if (pend_nz != '0) state <= REQ;
        end
        REQ: begin
          grant_err <= grant_bad;
          if (grant_ok) begin
            owner   <= grant_in;
            req_out <= grant_in;
            hold    <= 8'(HOLD_CYCLES - 1);
            state   <= OWN;
          end else if (wait_expired) begin
            timeout <= 1'b1;
            req_out <= '0;
            state   <= REL;
          end else if (pend_nz == '0) begin
            req_out <= '0;
            state   <= IDLE;
          end else begin
            req_out <= pend_nz;
          end
        end
        OWN: begin
          if ((grant_in & owner) == '0) begin
            lost_grant <= 1'b1;
            owner      <= '0;
            req_out    <= pend_nz;
            state      <= REQ;
          end else if (hold == 8'd0) begin
            done    <= owner;
            owner   <= '0;
            req_out <= '0;
            state   <= REL;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        REL: begin
          req_out <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester_4ch.sv
// tb/tb_arb_requester_4ch.sv - scoreboard bench for arb_requester_4ch
// Define ARB_REQ_TIMEOUT_EN for both RTL and bench to exercise the timeout path.
`timescale 1ns/1ps
module tb_arb_requester_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] push, req_out, grant_in, owner, done, overflow;
  logic       lost_grant, grant_err, timeout;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  int         model_pend [4];
  logic [3:0] model_ovf;
  logic       arb_auto;
  logic [3:0] last_req;

  always #5 clk = ~clk;

  arb_requester_4ch #(.NCH(4), .CNT_W(3), .HOLD_CYCLES(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .req_out(req_out), .grant_in(grant_in),
    .owner(owner), .done(done), .lost_grant(lost_grant), .grant_err(grant_err),
    .overflow(overflow), .timeout(timeout)
  );

  // Fixed-priority arbiter model: lowest index wins.
  function automatic logic [3:0] prio(input logic [3:0] r);
    logic [3:0] g;
    g = '0;
    for (int i = 3; i >= 0; i--) if (r[i]) begin g = '0; g[i] = 1'b1; end
    return g;
  endfunction

  task automatic tick();
    logic [3:0] e;
    @(posedge clk); #1;
    if (done !== 4'b0000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++; $display("FAIL done_unexpected got=%b exp=none", done);
      end else begin
        e = exp_q.pop_front();
        if (done !== e) begin miscompares++; $display("FAIL done_channel got=%b exp=%b", done, e); end
        for (int i = 0; i < 4; i++) if (e[i]) model_pend[i]--;
      end
    end
    if (arb_auto) grant_in = prio(last_req);
    last_req = req_out;
  endtask

  task automatic do_push(input logic [3:0] m);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (model_pend[i] < 7) begin
          model_pend[i]++;
          e = '0; e[i] = 1'b1;
          exp_q.push_back(e);
        end else begin
          model_ovf[i] = 1'b1;
        end
      end
    end
    push = m;
    tick();
    push = '0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_pend[i] = 0;
    model_ovf = '0;
  endtask

  task automatic test_reset();
    logic found;
    logic bad;
    rst_n = 1'b0; push = '0; grant_in = '0; arb_auto = 1'b0; last_req = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_out, owner, done, overflow, lost_grant, grant_err, timeout} !== 19'd0) begin
      miscompares++; $display("FAIL reset_values got=%b exp=0",
        {req_out, owner, done, overflow, lost_grant, grant_err, timeout});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({req_out, owner, done, timeout} !== 13'd0) begin
      miscompares++; $display("FAIL idle_after_reset got=%b exp=0", {req_out, owner, done, timeout});
    end
    arb_auto = 1'b1;
    do_push(4'b0010);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (owner === 4'b0010) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL reset_reach_own got=%b exp=0010", owner); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({owner, req_out, done} !== 12'd0) begin
      miscompares++; $display("FAIL async_reset got=%b exp=0", {owner, req_out, done});
    end
    arb_auto = 1'b0; grant_in = '0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1; last_req = '0; arb_auto = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ({owner, req_out, done} !== 12'd0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL post_reset_idle got=%b exp=0", {owner, req_out, done}); end
  endtask

  task automatic test_single();
    int own_cnt, done_cnt, g_first, o_first;
    logic rel_bad, tail_bad;
    own_cnt = 0; done_cnt = 0; g_first = -1; o_first = -1; rel_bad = 1'b0; tail_bad = 1'b0;
    arb_auto = 1'b1;
    do_push(4'b0100);
    for (int k = 0; k < 25; k++) begin
      tick();
      if (owner === 4'b0100) begin own_cnt++; if (o_first < 0) o_first = k; end
      else if (owner !== 4'b0000) rel_bad = 1'b1;
      if (done !== 4'b0000) begin done_cnt++; if (req_out !== 4'b0000) rel_bad = 1'b1; end
      if (k >= 15 && req_out !== 4'b0000) tail_bad = 1'b1;
      if (g_first < 0 && grant_in === 4'b0100) g_first = k;
    end
    vectors++;
    if (own_cnt !== 4) begin miscompares++; $display("FAIL single_own_cycles got=%0d exp=4", own_cnt); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
    vectors++;
    if (o_first !== g_first + 1) begin
      miscompares++; $display("FAIL grant_latency got=%0d exp=%0d", o_first, g_first + 1);
    end
    vectors++;
    if (rel_bad) begin miscompares++; $display("FAIL single_rel got=1 exp=0"); end
    vectors++;
    if (tail_bad || exp_q.size() != 0) begin
      miscompares++; $display("FAIL single_pend_clear got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    int done_cnt;
    arb_auto = 1'b0; grant_in = '0;
    for (int k = 0; k < 7; k++) do_push(4'b0001);
    vectors++;
    if (overflow !== 4'b0000) begin miscompares++; $display("FAIL sat_no_overflow got=%b exp=0000", overflow); end
    vectors++;
    if (req_out !== 4'b0001) begin miscompares++; $display("FAIL sat_req got=%b exp=0001", req_out); end
    do_push(4'b0001);
    vectors++;
    if (overflow !== model_ovf) begin miscompares++; $display("FAIL sat_overflow got=%b exp=%b", overflow, model_ovf); end
    arb_auto = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 110; k++) begin
      tick();
      if (done !== 4'b0000) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 7) begin miscompares++; $display("FAIL sat_done_count got=%0d exp=7", done_cnt); end
    vectors++;
    if (exp_q.size() != 0 || req_out !== 4'b0000) begin
      miscompares++; $display("FAIL sat_drain got=%0d exp=0", exp_q.size());
    end
    vectors++;
    if (overflow !== model_ovf) begin miscompares++; $display("FAIL sat_sticky got=%b exp=%b", overflow, model_ovf); end
  endtask

  task automatic test_illegal();
    logic found;
    arb_auto = 1'b0; grant_in = '0;
    do_push(4'b0001);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (req_out === 4'b0001) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL illegal_reach_req got=%b exp=0001", req_out); end
    grant_in = 4'b0011;
    tick();
    vectors++;
    if ({grant_err, owner} !== 5'b1_0000) begin
      miscompares++; $display("FAIL grant_err_multi got=%b exp=10000", {grant_err, owner});
    end
    grant_in = '0;
    tick();
    vectors++;
    if ({grant_err, owner, req_out} !== 9'b0_0000_0001) begin
      miscompares++; $display("FAIL grant_err_stay_req got=%b exp=000000001", {grant_err, owner, req_out});
    end
    grant_in = 4'b1000;
    tick();
    vectors++;
    if ({grant_err, owner} !== 5'b1_0000) begin
      miscompares++; $display("FAIL grant_err_unreq got=%b exp=10000", {grant_err, owner});
    end
    grant_in = '0;
    arb_auto = 1'b1;
    repeat (20) tick();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL illegal_recover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_lost();
    logic found;
    arb_auto = 1'b1;
    do_push(4'b0100);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (owner === 4'b0100) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL lost_reach_own got=%b exp=0100", owner); end
    tick();
    arb_auto = 1'b0; grant_in = '0;
    tick();
    vectors++;
    if ({lost_grant, owner, req_out} !== 9'b1_0000_0100) begin
      miscompares++; $display("FAIL lost_grant got=%b exp=100000100", {lost_grant, owner, req_out});
    end
    vectors++;
    if (exp_q.size() != 1) begin miscompares++; $display("FAIL lost_pend_kept got=%0d exp=1", exp_q.size()); end
    tick();
    vectors++;
    if (lost_grant !== 1'b0) begin miscompares++; $display("FAIL lost_pulse_width got=%b exp=0", lost_grant); end
    arb_auto = 1'b1;
    repeat (20) tick();
    vectors++;
    if (exp_q.size() != 0 || req_out !== 4'b0000) begin
      miscompares++; $display("FAIL lost_complete got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    logic found;
    int   n;
    arb_auto = 1'b0; grant_in = '0;
    do_push(4'b1000);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (req_out === 4'b1000) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL to_reach_req got=%b exp=1000", req_out); end
`ifdef ARB_REQ_TIMEOUT_EN
    n = 0; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (timeout === 1'b1) begin found = 1'b1; n = k; end
    end
    vectors++;
    if (n !== 15) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    vectors++;
    if (req_out !== 4'b0000) begin miscompares++; $display("FAIL timeout_req_drop got=%b exp=0000", req_out); end
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      tick();
      if (req_out === 4'b1000) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL timeout_rerequest got=%b exp=1000", req_out); end
`else
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (timeout !== 1'b0 || req_out !== 4'b1000) n++;
    end
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL req_waits_forever got=%0d exp=0", n); end
`endif
    arb_auto = 1'b1;
    repeat (20) tick();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL to_complete got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; push = '0; grant_in = '0; arb_auto = 1'b0; last_req = '0;
    clear_model();
    test_reset();
    test_single();
    test_saturation();
    test_illegal();
    test_lost();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
